// File: rtl/fetch_pkg.sv
// Shared fetch definitions: default datapath width, PC step, queue entry.
// Imported by fetch_queue and inst_fifo.
package fetch_pkg;

    localparam int XLEN_DEF = 32;
    localparam int PC_INC   = 4;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Instruction queue storage: power-of-two ring buffer with occupancy count.
// Simultaneous push and pop are allowed at any occupancy, including full.
module inst_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  entry_t                     wdata,
    output entry_t                     rdata,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q;
    logic [PW-1:0]   rd_ptr_d;
    logic [CW-1:0]   count_q;
    logic [CW-1:0]   count_d;
    logic            do_push;
    logic            do_pop;

    // Qualify requests and advance pointers; pointers wrap on their own width.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; empty entries are never presented.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: issues SRAM reads, queues {pc, inst} for decode, redirects.
// Define FETCH_QUEUE_BYPASS_EN to present a response in its arrival cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ADDR_W   = 16,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       im_req,
    output logic [ADDR_W-1:0]          im_addr,
    input  logic [XLEN-1:0]            im_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } entry_t;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] req_pc_q;
    logic [XLEN-1:0] req_pc_d;
    logic            inflight_q;
    logic            inflight_d;
    logic [XLEN-1:0] hold_pc_q;
    logic [XLEN-1:0] hold_pc_d;
    logic [XLEN-1:0] hold_inst_q;
    logic [XLEN-1:0] hold_inst_d;

    logic            rsp_vld;
    logic            byp;
    logic            q_empty;
    logic            push;
    logic            pop;
    logic [CW:0]     occ;
    logic [CW-1:0]   q_count;
    entry_t          wdata;
    entry_t          head;

    // Request issue: queued plus in-flight entries must leave room.
    always_comb begin
        occ     = {1'b0, q_count} + {{CW{1'b0}}, inflight_q};
        im_req  = !rst && !redirect && (occ < (CW+1)'(DEPTH));
        im_addr = pc_q[ADDR_W-1:0];
    end

    // Response capture, optional bypass, and decode-side presentation.
    always_comb begin
        rsp_vld    = inflight_q && !redirect;
        q_empty    = (q_count == '0);
`ifdef FETCH_QUEUE_BYPASS_EN
        byp        = rsp_vld && q_empty;
`else
        byp        = 1'b0;
`endif
        out_valid  = !q_empty || byp;
        if (!q_empty) begin
            out_pc   = head.pc;
            out_inst = head.inst;
        end else if (byp) begin
            out_pc   = req_pc_q;
            out_inst = im_rdata;
        end else begin
            out_pc   = hold_pc_q;
            out_inst = hold_inst_q;
        end
        pop        = out_valid && out_ready && !redirect;
        push       = rsp_vld && !(byp && out_ready);
        wdata.pc   = req_pc_q;
        wdata.inst = im_rdata;
    end

    // Next-state for PC, request tracking and held decode outputs.
    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = im_req;
        hold_pc_d   = out_pc;
        hold_inst_d = out_inst;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (im_req) begin
            pc_d     = pc_q + XLEN'(PC_INC);
            req_pc_d = pc_q;
        end
    end

    // Fetch state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            req_pc_q    <= '0;
            inflight_q  <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
        end else begin
            pc_q        <= pc_d;
            req_pc_q    <= req_pc_d;
            inflight_q  <= inflight_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
        end
    end

    inst_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (head),
        .count (q_count)
    );

    assign count = q_count;

endmodule
